bnn_param_loader: RTL
=====================

# bnn_param_loader

Byte-stream parameter loader for the BNN datapath. Accepts command bytes over a valid/ready interface, assembles them into byte-aligned input, weight and bias fields, and commits a complete frame atomically. It then pulses the BNN start, waits for completion with a bounded timeout, and holds the captured result for readback. It sits between the SPI byte deserialiser and the BNN core, replacing fixed-width packing with parametrised field widths, flow control, abort and error reporting.

## Interface
- IN_W, 4: input vector width (bits)
- WT_W, 16: weight field width (bits)
- BS_W, 16: bias field width (bits)
- RES_W, 4: BNN result width (bits)
- TIMEOUT_CYC, 256: max cycles in RUN awaiting `bnn_done`; 0 disables the timeout
- Derived, not overridable: NB_IN=ceil(IN_W/8), NB_WT=ceil(WT_W/8), NB_BS=ceil(BS_W/8), NB=NB_IN+NB_WT+NB_BS
- clk  in  1  single clock; all logic is on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  byte present on `in_byte`
- in_byte  in  8  command byte
- in_ready  out  1  loader accepts a byte this cycle
- frame_abort  in  1  discard the partial frame or abandon the pending run
- in_vec  out  IN_W  committed input vector
- weights  out  WT_W  committed weights
- bias  out  BS_W  committed bias
- bnn_start  out  1  one-cycle start pulse to the BNN
- bnn_done  in  1  BNN result valid strobe
- bnn_result  in  RES_W  BNN result
- result  out  RES_W  captured result
- result_valid  out  1  `result` holds a fresh capture
- busy  out  1  high in RUN
- timeout_err  out  1  sticky error: the last run timed out
- byte_cnt  out  $clog2(NB+1)  bytes accepted in the current frame

## Operation
- States: LOAD (reset state) and RUN.
- `in_ready` = (state==LOAD). It is combinational from state only and never depends on `in_valid`.
- **Accept:** a byte is accepted when `in_valid && in_ready && !frame_abort`.
  - The byte is written to shadow byte slot `byte_cnt`, then `byte_cnt` increments.
- **Field layout:** each field is byte-aligned and little-endian, in the order input, weights, bias.
  - Slots 0..NB_IN-1 form the input field, the next NB_WT slots form weights, and the last NB_BS slots form bias.
  - Each field uses its low W bits; unused high bits of a field's top byte are ignored.
- **Commit:** when the accepted byte is slot NB-1, all three output fields load from the shadow registers and this last byte on the same edge.
  - On that edge `byte_cnt` returns to 0 and the state moves to RUN.
  - `in_vec`/`weights`/`bias` change only at commit. The BNN never sees a partial frame.
  - The commit also clears `timeout_err`.
- **First byte of a frame** (slot 0) clears `result_valid`.
- **RUN:**
  - A cycle counter starts at 0 on entry.
  - `bnn_done` captures `bnn_result` into `result`, sets `result_valid`, and returns to LOAD.
  - If TIMEOUT_CYC≠0 and the counter reaches TIMEOUT_CYC-1 without `bnn_done`, the block sets `timeout_err`, leaves `result_valid` at 0, and returns to LOAD.
  - If `bnn_done` and the timeout occur on the same cycle, `bnn_done` wins.
- `bnn_done` outside RUN is ignored.
- **frame_abort:**
  - In LOAD it sets `byte_cnt` to 0 and clears `result_valid`. A simultaneous byte is dropped.
  - In RUN it returns to LOAD with no capture and no error. A simultaneous `bnn_done` is ignored.
- Committed fields persist across aborts and timeouts until the next commit.
- Reset values: all outputs 0, except `in_ready`=1 (state LOAD). Shadow registers and the cycle counter are also 0.
- Reset mid-frame or mid-run discards everything, with no `bnn_start` or capture.

## Timing
- Accepting a byte costs 1 cycle. Back-to-back bytes are accepted at 1 per cycle in LOAD.
- The last byte is accepted at edge k.
  - Fields are visible and `busy`=1 after edge k.
  - `bnn_start` is high for exactly the cycle after edge k, and is deasserted at edge k+1.
  - `in_ready`=0 from edge k.
- `bnn_done` sampled at edge m.
  - `result`/`result_valid` are updated after edge m.
  - `in_ready`=1 in the cycle after edge m.
- Frame-to-frame minimum: NB cycles of loading plus 1 start cycle plus BNN latency.

## Test plan
- **Default frame:** bytes A5,34,12,78,56 back-to-back, then `bnn_done` with `bnn_result`=9 three cycles after start.
  - Expect `in_vec`=5, `weights`=1234h and `bias`=5678h, all appearing together after byte 5.
  - Expect a single-cycle `bnn_start`.
  - Expect `result`=9, `result_valid`=1, `busy`=0.
- **Backpressure:** hold `in_valid`=1 with new bytes during RUN.
  - Expect `in_ready`=0 and no byte consumed (`byte_cnt` stays 0).
  - Expect the first byte after `bnn_done` to land in slot 0 and clear `result_valid`.
- **Timeout:** with TIMEOUT_CYC=8, never assert `bnn_done`.
  - Expect `timeout_err`=1 and a return to LOAD after 8 RUN cycles, with `result_valid`=0.
  - The next commit clears `timeout_err`.
- **Abort:** send 2 bytes, then `frame_abort` together with a third byte, then a full frame 01,FF,00,00,80.
  - Expect the third byte dropped.
  - Expect `in_vec`=1, `weights`=00FFh, `bias`=8000h.
- **Reset:** assert `rst_n`=0 after 3 bytes.
  - Expect `byte_cnt`=0, all fields 0, and no `bnn_start`.
  - A full frame after reset commits normally.
- **Non-byte widths:** IN_W=3, WT_W=12, BS_W=9 (NB=5). Send bytes FF,AB,FC,CD,FE.
  - Expect `in_vec`=7, `weights`=CABh, `bias`=0CDh.

Source files
------------

// File: rtl/bnn_param_loader_if.sv
// Byte-stream handshake between the SPI deserialiser and the BNN parameter loader.
interface bnn_param_loader_if;
   logic       in_valid;
   logic [7:0] in_byte;
   logic       in_ready;

   modport master (output in_valid, output in_byte, input in_ready);
   modport slave  (input in_valid, input in_byte, output in_ready);
endinterface

// File: rtl/bnn_param_loader.sv
// Assembles byte-aligned input/weight/bias fields from a byte stream, commits them
// atomically, starts the BNN and captures its result with a bounded wait.
module bnn_param_loader #(
   parameter  int unsigned IN_W        = 4,
   parameter  int unsigned WT_W        = 16,
   parameter  int unsigned BS_W        = 16,
   parameter  int unsigned RES_W       = 4,
   parameter  int unsigned TIMEOUT_CYC = 256,
   localparam int unsigned NB_IN       = (IN_W + 7) / 8,
   localparam int unsigned NB_WT       = (WT_W + 7) / 8,
   localparam int unsigned NB_BS       = (BS_W + 7) / 8,
   localparam int unsigned NB          = NB_IN + NB_WT + NB_BS,
   localparam int unsigned CW          = $clog2(NB + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   bnn_param_loader_if.slave in_bus,
   input  logic              frame_abort,
   output logic [IN_W-1:0]   in_vec,
   output logic [WT_W-1:0]   weights,
   output logic [BS_W-1:0]   bias,
   output logic              bnn_start,
   input  logic              bnn_done,
   input  logic [RES_W-1:0]  bnn_result,
   output logic [RES_W-1:0]  result,
   output logic              result_valid,
   output logic              busy,
   output logic              timeout_err,
   output logic [CW-1:0]     byte_cnt
);

   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int unsigned FW = NB * 8;

   typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [7:0]    shadow [NB-1];
   logic [FW-1:0] frame_c;
   logic [TW-1:0] run_cnt;
   logic          accept_c, commit_c, capture_c, expire_c;
   logic          unused_pad_c;

   assign in_bus.in_ready = (state_q == LOAD);

   // Full frame as seen on the committing edge: stored slots plus the byte in flight.
   always_comb begin
      frame_c = '0;
      for (int unsigned i = 0; i < NB - 1; i++) begin
         frame_c[i*8 +: 8] = shadow[i];
      end
      frame_c[(NB-1)*8 +: 8] = in_bus.in_byte;
   end

   // Padding bits above each field width are deliberately discarded.
   assign unused_pad_c = ^frame_c;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= LOAD;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      accept_c  = 1'b0;
      commit_c  = 1'b0;
      capture_c = 1'b0;
      expire_c  = 1'b0;
      case (state_q)
         LOAD: begin
            accept_c = in_bus.in_valid && !frame_abort;
            if (accept_c && (byte_cnt == CW'(NB - 1))) begin
               commit_c = 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            // Abort beats done, done beats timeout.
            if (frame_abort) begin
               state_d = LOAD;
            end else if (bnn_done) begin
               capture_c = 1'b1;
               state_d   = LOAD;
            end else if ((TIMEOUT_CYC != 0) && (run_cnt == TW'(TIMEOUT_CYC - 1))) begin
               expire_c = 1'b1;
               state_d  = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         byte_cnt     <= '0;
         in_vec       <= '0;
         weights      <= '0;
         bias         <= '0;
         bnn_start    <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         timeout_err  <= 1'b0;
         run_cnt      <= '0;
         for (int unsigned i = 0; i < NB - 1; i++) shadow[i] <= '0;
      end else begin
         bnn_start <= commit_c;
         busy      <= (state_d == RUN);
         run_cnt   <= ((state_q == RUN) && (state_d == RUN)) ? run_cnt + TW'(1) : '0;

         if ((state_q == LOAD) && frame_abort) begin
            byte_cnt     <= '0;
            result_valid <= 1'b0;
         end else if (accept_c) begin
            if (byte_cnt == '0) result_valid <= 1'b0;
            if (commit_c) begin
               byte_cnt    <= '0;
               in_vec      <= frame_c[IN_W-1:0];
               weights     <= frame_c[NB_IN*8 +: WT_W];
               bias        <= frame_c[(NB_IN+NB_WT)*8 +: BS_W];
               timeout_err <= 1'b0;
            end else begin
               byte_cnt <= byte_cnt + CW'(1);
               for (int unsigned i = 0; i < NB - 1; i++) begin
                  if (byte_cnt == CW'(i)) shadow[i] <= in_bus.in_byte;
               end
            end
         end

         if (capture_c) begin
            result       <= bnn_result;
            result_valid <= 1'b1;
         end
         if (expire_c) timeout_err <= 1'b1;
      end
   end

endmodule
